// File: rtl/xge_tx_arbiter.sv
// ---------------------------------------------------------------------------
// xge_tx_arbiter
//
// Round-robin packet arbiter sharing the single xge_mac pkt_tx_* interface
// between NUM_SRC packet sources. One source is granted per packet and keeps
// the grant until its EOP beat transfers. All MAC-side outputs are registered.
// Lives in the 156.25 MHz core clock domain.
//
// Optional feature (compile-time macro XGE_TX_ARB_PRIO_EN):
//   defined   - source 0 has strict priority. Sources 1..NUM_SRC-1 rotate
//               among themselves, and only their grants move the pointer.
//   undefined - pure round-robin over all sources.
//
// Parameters:
//   NUM_SRC  number of sources (2..8)
//   IDX_W    grant index width, 2**IDX_W >= NUM_SRC
//
// Ports:
//   clk_156m25, reset_156m25   clock, synchronous active-high reset
//   src_data/mod/val/sop/eop   per-source beat bus (source i in slice i)
//   src_rdy                    per-source beat accept (combinational)
//   pkt_tx_full                MAC TX FIFO almost-full
//   pkt_tx_data/mod/val/sop/eop registered beat stream to the MAC
//   arb_busy                   packet in progress
//   arb_grant                  current or last granted source
//   err_proto                  one-cycle pulse on orphan beat or mid-packet SOP
// ---------------------------------------------------------------------------
module xge_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic                  clk_156m25,
  input  logic                  reset_156m25,
  input  logic [NUM_SRC*64-1:0] src_data,
  input  logic [NUM_SRC*3-1:0]  src_mod,
  input  logic [NUM_SRC-1:0]    src_val,
  input  logic [NUM_SRC-1:0]    src_sop,
  input  logic [NUM_SRC-1:0]    src_eop,
  output logic [NUM_SRC-1:0]    src_rdy,
  input  logic                  pkt_tx_full,
  output logic [63:0]           pkt_tx_data,
  output logic [2:0]            pkt_tx_mod,
  output logic                  pkt_tx_val,
  output logic                  pkt_tx_sop,
  output logic                  pkt_tx_eop,
  output logic                  arb_busy,
  output logic [IDX_W-1:0]      arb_grant,
  output logic                  err_proto
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [IDX_W-1:0] last;        // round-robin pointer: last source served
  logic             first_beat;  // next transferred beat is the packet's first

  logic [NUM_SRC-1:0] req;       // SOP beat waiting: a request for the MAC
  logic [NUM_SRC-1:0] orphan;    // non-SOP beat while idle: dropped
  logic [NUM_SRC-1:0] rr_req;    // requests taking part in the rotation

  assign req    = src_val & src_sop;
  assign orphan = src_val & ~src_sop;

`ifdef XGE_TX_ARB_PRIO_EN
  // Source 0 is handled ahead of the rotation, so it never enters it.
  assign rr_req = req & ~NUM_SRC'(1);
`else
  assign rr_req = req;
`endif

  // -------------------------------------------------------------------------
  // Winner search: first requester at last+1, last+2, ... (mod NUM_SRC).
  // -------------------------------------------------------------------------
  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
`ifdef XGE_TX_ARB_PRIO_EN
    if (req[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_SRC);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && rr_req[i] && cand == IDX_W'(i)) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Granted-source beat mux.
  // -------------------------------------------------------------------------
  logic [63:0] g_data;
  logic [2:0]  g_mod;
  logic        g_val;
  logic        g_sop;
  logic        g_eop;

  always_comb begin
    g_data = '0;
    g_mod  = '0;
    g_val  = 1'b0;
    g_sop  = 1'b0;
    g_eop  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_grant == IDX_W'(i)) begin
        g_data = src_data[64*i +: 64];
        g_mod  = src_mod[3*i +: 3];
        g_val  = src_val[i];
        g_sop  = src_sop[i];
        g_eop  = src_eop[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Beat accept. In IDLE only orphan beats are accepted (and thrown away);
  // request beats wait for XFER. In XFER only the granted source is ready,
  // gated directly by full so no beat is taken while the MAC is almost full.
  // Held low during reset so nothing is consumed in the reset cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    src_rdy = '0;
    if (!reset_156m25) begin
      if (state == IDLE) begin
        src_rdy = orphan;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          src_rdy[i] = (arb_grant == IDX_W'(i)) & ~pkt_tx_full;
        end
      end
    end
  end

  logic xfer;
  assign xfer = (state == XFER) & g_val & ~pkt_tx_full;

  // -------------------------------------------------------------------------
  // Control FSM and registered MAC outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_156m25) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // here samples pre-edge values regardless of statement order.
    if (reset_156m25) begin
      state       <= IDLE;
      last        <= IDX_W'(NUM_SRC - 1);
      first_beat  <= 1'b0;
      arb_busy    <= 1'b0;
      arb_grant   <= '0;
      err_proto   <= 1'b0;
      pkt_tx_data <= '0;
      pkt_tx_mod  <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
    end else begin
      pkt_tx_val <= xfer;
      // A SOP on anything but the first beat is not passed to the MAC.
      pkt_tx_sop <= xfer & g_sop & first_beat;
      pkt_tx_eop <= xfer & g_eop;
      if (xfer) begin
        pkt_tx_data <= g_data;
        pkt_tx_mod  <= g_mod;
      end
      err_proto <= 1'b0;

      case (state)
        IDLE: begin
          if (|orphan) begin
            err_proto <= 1'b1;
          end
          if (found) begin
            arb_grant  <= winner;
            arb_busy   <= 1'b1;
            first_beat <= 1'b1;
            state      <= XFER;
          end
        end

        XFER: begin
          if (xfer) begin
            first_beat <= 1'b0;
            if (g_sop && !first_beat) begin
              err_proto <= 1'b1;
            end
            if (g_eop) begin
              arb_busy <= 1'b0;
              state    <= IDLE;
`ifdef XGE_TX_ARB_PRIO_EN
              if (arb_grant != '0) begin
                last <= arb_grant;
              end
`else
              last <= arb_grant;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xge_tx_arbiter
//
// Directed bench for xge_tx_arbiter. Sources are modelled by a queue of beats
// (sq); each source presents its oldest beat and drops it once it is accepted.
// Expected MAC beats, in expected arbitration order, go into a scoreboard
// queue (eq) when stimulus is queued; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_xge_tx_arbiter;

  localparam int NUM_SRC = 4;
  localparam int IDX_W   = 2;

  typedef struct {
    int          src;
    logic [63:0] data;
    logic [2:0]  mod;
    logic        sop;
    logic        eop;
  } beat_t;

  logic                  clk_156m25 = 1'b0;
  logic                  reset_156m25;
  logic [NUM_SRC*64-1:0] src_data;
  logic [NUM_SRC*3-1:0]  src_mod;
  logic [NUM_SRC-1:0]    src_val;
  logic [NUM_SRC-1:0]    src_sop;
  logic [NUM_SRC-1:0]    src_eop;
  logic [NUM_SRC-1:0]    src_rdy;
  logic                  pkt_tx_full;
  logic [63:0]           pkt_tx_data;
  logic [2:0]            pkt_tx_mod;
  logic                  pkt_tx_val;
  logic                  pkt_tx_sop;
  logic                  pkt_tx_eop;
  logic                  arb_busy;
  logic [IDX_W-1:0]      arb_grant;
  logic                  err_proto;

  always #5 clk_156m25 = ~clk_156m25;

  xge_tx_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) dut (
    .clk_156m25   (clk_156m25),
    .reset_156m25 (reset_156m25),
    .src_data     (src_data),
    .src_mod      (src_mod),
    .src_val      (src_val),
    .src_sop      (src_sop),
    .src_eop      (src_eop),
    .src_rdy      (src_rdy),
    .pkt_tx_full  (pkt_tx_full),
    .pkt_tx_data  (pkt_tx_data),
    .pkt_tx_mod   (pkt_tx_mod),
    .pkt_tx_val   (pkt_tx_val),
    .pkt_tx_sop   (pkt_tx_sop),
    .pkt_tx_eop   (pkt_tx_eop),
    .arb_busy     (arb_busy),
    .arb_grant    (arb_grant),
    .err_proto    (err_proto)
  );

  beat_t sq[$];      // beats waiting at the sources
  beat_t eq[$];      // expected MAC beats, in order
  int    out_cyc[$]; // cycle index of every observed MAC beat
  int    cyc     = 0;
  int    out_cnt = 0;
  int    err_cnt = 0;
  int    checks  = 0;
  int    passes  = 0;
  beat_t mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present the oldest queued beat of every source.
  task automatic drive_srcs();
    logic [NUM_SRC-1:0] seen;
    int s;
    seen     = '0;
    src_val  = '0;
    src_sop  = '0;
    src_eop  = '0;
    src_data = '0;
    src_mod  = '0;
    foreach (sq[j]) begin
      s = sq[j].src;
      if (!seen[s]) begin
        seen[s]              = 1'b1;
        src_val[s]           = 1'b1;
        src_sop[s]           = sq[j].sop;
        src_eop[s]           = sq[j].eop;
        src_data[64*s +: 64] = sq[j].data;
        src_mod[3*s +: 3]    = sq[j].mod;
      end
    end
  endtask

  // One clock: retire accepted beats on the edge, re-drive 1 time unit later.
  task automatic tick();
    logic [NUM_SRC-1:0] acc;
    @(posedge clk_156m25);
    acc = src_val & src_rdy;
    cyc++;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (acc[s]) begin
        for (int j = 0; j < sq.size(); j++) begin
          if (sq[j].src == s) begin
            sq.delete(j);
            break;
          end
        end
      end
    end
    #1;
    drive_srcs();
  endtask

  // Queue an n-beat packet; bad_sop marks a beat that wrongly carries SOP.
  task automatic add_pkt(input int src, input int n, input logic [63:0] seed, input int bad_sop);
    beat_t x;
    for (int b = 0; b < n; b++) begin
      x.src  = src;
      x.data = seed + 64'(b);
      x.mod  = 3'(b * 3 + src + 1);
      x.sop  = (b == 0) || (b == bad_sop);
      x.eop  = (b == n - 1);
      sq.push_back(x);
      x.sop  = (b == 0);
      eq.push_back(x);
    end
  endtask

  task automatic wait_out(input int n, input int budget);
    int b;
    b = budget;
    while (out_cnt < n && b > 0) begin
      tick();
      b--;
    end
    check("wait_out_budget", 64'(out_cnt >= n), 64'd1);
  endtask

  task automatic do_reset();
    reset_156m25 = 1'b1;
    sq.delete();
    eq.delete();
    drive_srcs();
    tick();
    tick();
    reset_156m25 = 1'b0;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk_156m25) begin
    if (pkt_tx_val) begin
      out_cnt++;
      out_cyc.push_back(cyc);
      check("beat_expected", 64'(eq.size() > 0), 64'd1);
      if (eq.size() > 0) begin
        mon_e = eq.pop_front();
        check("beat_data",  pkt_tx_data,       mon_e.data);
        check("beat_mod",   64'(pkt_tx_mod),   64'(mon_e.mod));
        check("beat_sop",   64'(pkt_tx_sop),   64'(mon_e.sop));
        check("beat_eop",   64'(pkt_tx_eop),   64'(mon_e.eop));
        check("beat_grant", 64'(arb_grant),    64'(mon_e.src));
      end
    end
    if (err_proto) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int    p;
    int    base;
    int    w0;
    int    e0;
    int    pend;
    beat_t o;

    reset_156m25 = 1'b1;
    pkt_tx_full  = 1'b0;
    drive_srcs();

    // ---- reset state -----------------------------------------------------
    repeat (3) tick();
    #1;
    check("rst_val",   64'(pkt_tx_val), 64'd0);
    check("rst_sop",   64'(pkt_tx_sop), 64'd0);
    check("rst_eop",   64'(pkt_tx_eop), 64'd0);
    check("rst_data",  pkt_tx_data,     64'd0);
    check("rst_mod",   64'(pkt_tx_mod), 64'd0);
    check("rst_rdy",   64'(src_rdy),    64'd0);
    check("rst_busy",  64'(arb_busy),   64'd0);
    check("rst_grant", 64'(arb_grant),  64'd0);
    check("rst_err",   64'(err_proto),  64'd0);
    reset_156m25 = 1'b0;

    // ---- single source 2, 3 beats: output 2 cycles after request ----------
    add_pkt(2, 3, 64'hA5A5_0000_0000_0200, -1);
    drive_srcs();
    p    = cyc;
    base = out_cnt;
    wait_out(base + 3, 20);
    check("t1_beat1_cycle", 64'(out_cyc[base]),     64'(p + 2));
    check("t1_beat2_cycle", 64'(out_cyc[base + 1]), 64'(p + 3));
    check("t1_beat3_cycle", 64'(out_cyc[base + 2]), 64'(p + 4));

    // ---- all four sources, two 1-beat packets each ------------------------
    do_reset();
`ifdef XGE_TX_ARB_PRIO_EN
    add_pkt(0, 1, 64'h1000_0000_0000_0000, -1);
    add_pkt(0, 1, 64'h1000_0000_0000_0100, -1);
    for (int r = 0; r < 2; r++)
      for (int s = 1; s < NUM_SRC; s++)
        add_pkt(s, 1, 64'h1000_0000_0000_0000 + 64'(s * 16 + r * 256), -1);
`else
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NUM_SRC; s++)
        add_pkt(s, 1, 64'h1000_0000_0000_0000 + 64'(s * 16 + r * 256), -1);
`endif
    drive_srcs();
    base = out_cnt;
    wait_out(base + 8, 60);
    for (int k = 0; k < 7; k++)
      check("t2_packet_gap", 64'(out_cyc[base + k + 1] - out_cyc[base + k]), 64'd2);
    check("t2_all_served", 64'(sq.size()), 64'd0);

    // ---- backpressure: full for 5 cycles mid-packet -----------------------
    repeat (3) tick();
    add_pkt(1, 4, 64'hBEEF_0000_0000_1000, -1);
    drive_srcs();
    base = out_cnt;
    wait_out(base + 1, 20);
    pkt_tx_full = 1'b1;
    w0 = out_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_rdy_blocked", 64'(src_rdy), 64'd0);
      tick();
    end
    pkt_tx_full = 1'b0;
    check("t3_trailing_le1", 64'(out_cnt - w0 <= 1), 64'd1);
    check("t3_busy_held", 64'(arb_busy), 64'd1);
    wait_out(base + 4, 20);
    repeat (3) tick();
    check("t3_beats_out", 64'(out_cnt - base), 64'd4);

    // ---- orphan beat on source 1 in IDLE ----------------------------------
    repeat (2) tick();
    o.src  = 1;
    o.data = 64'hDEAD_0000_0000_0001;
    o.mod  = 3'd2;
    o.sop  = 1'b0;
    o.eop  = 1'b1;
    sq.push_back(o);
    drive_srcs();
    e0   = err_cnt;
    base = out_cnt;
    repeat (5) tick();
    check("t4_err_pulse", 64'(err_cnt - e0), 64'd1);
    check("t4_no_output", 64'(out_cnt - base), 64'd0);
    check("t4_consumed",  64'(sq.size()), 64'd0);
    check("t4_idle",      64'(arb_busy), 64'd0);

    // ---- mid-packet SOP: forwarded with sop cleared, err pulses -----------
    add_pkt(0, 3, 64'hC0DE_0000_0000_0000, 1);
    drive_srcs();
    e0   = err_cnt;
    base = out_cnt;
    wait_out(base + 3, 20);
    repeat (2) tick();
    check("t4b_midsop_err", 64'(err_cnt - e0), 64'd1);

    // ---- reset on beat 2 of a 4-beat packet -------------------------------
    repeat (2) tick();
    add_pkt(3, 4, 64'h5555_0000_0000_3000, -1);
    drive_srcs();
    base = out_cnt;
    wait_out(base + 1, 20);
    reset_156m25 = 1'b1;
    pend = sq.size();
    for (int k = 0; k < pend; k++) void'(eq.pop_back());
    sq.delete();
    drive_srcs();
    tick();
    #1;
    check("t5_val",   64'(pkt_tx_val), 64'd0);
    check("t5_sop",   64'(pkt_tx_sop), 64'd0);
    check("t5_eop",   64'(pkt_tx_eop), 64'd0);
    check("t5_data",  pkt_tx_data,     64'd0);
    check("t5_busy",  64'(arb_busy),   64'd0);
    check("t5_grant", 64'(arb_grant),  64'd0);
    check("t5_beats_before_reset", 64'(out_cnt - base), 64'd2);
    reset_156m25 = 1'b0;
    add_pkt(3, 2, 64'h6666_0000_0000_3100, -1);
    drive_srcs();
    base = out_cnt;
    wait_out(base + 2, 20);

    // ---- sources 0 and 2 compete ------------------------------------------
    repeat (2) tick();
`ifdef XGE_TX_ARB_PRIO_EN
    for (int r = 0; r < 3; r++) add_pkt(0, 1, 64'h7000_0000_0000_0000 + 64'(r), -1);
    for (int r = 0; r < 3; r++) add_pkt(2, 1, 64'h7200_0000_0000_0000 + 64'(r), -1);
`else
    for (int r = 0; r < 3; r++) begin
      add_pkt(0, 1, 64'h7000_0000_0000_0000 + 64'(r), -1);
      add_pkt(2, 1, 64'h7200_0000_0000_0000 + 64'(r), -1);
    end
`endif
    drive_srcs();
    base = out_cnt;
    wait_out(base + 6, 60);

    repeat (4) tick();
    check("final_scoreboard_empty", 64'(eq.size()), 64'd0);
    check("final_sources_empty",    64'(sq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
